// File: rtl/ipsxe_floating_point_round_pipe_v1_0.sv
// Pipelined mantissa rounding unit: drops DROP low bits of a wide product and rounds the
// kept field (RNE/RTZ/RUP/RDN), reporting carry-out and inexact through a valid/ready pipe.
module ipsxe_floating_point_round_pipe_v1_0 #(
  parameter int IN_WIDTH    = 60,
  parameter int DROP        = 9,
  parameter int PIPE_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [IN_WIDTH-1:0]      i_data,
  input  logic                     i_sign,
  input  logic [1:0]               i_rnd_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [IN_WIDTH-DROP-1:0] o_data,
  output logic                     o_carry,
  output logic                     o_inexact,
  output logic                     o_sign
);

  localparam int OW = IN_WIDTH - DROP;

  logic [OW-1:0] kept;
  logic          lsb;
  logic          guard;
  logic          sticky;
  logic          inc;
  logic          inexact;

  assign kept    = i_data[IN_WIDTH-1:DROP];
  assign lsb     = i_data[DROP];
  assign guard   = i_data[DROP-1];
  assign sticky  = |i_data[DROP-2:0];
  assign inexact = guard | sticky;

  // Directed modes round away from zero only when that direction moves toward the target infinity.
  always_comb begin
    inc = 1'b0;
    case (i_rnd_mode)
      2'b00:   inc = guard & (sticky | lsb);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~i_sign & inexact;
      default: inc = i_sign & inexact;
    endcase
  end

  generate
    if (PIPE_STAGES == 1) begin : g_p1
      logic          v_q;
      logic [OW-1:0] data_q;
      logic          carry_q;
      logic          inex_q;
      logic          sign_q;
      logic          ready1;
      logic [OW:0]   sum_d;

      assign sum_d  = {1'b0, kept} + {{OW{1'b0}}, inc};
      assign ready1 = ~v_q | i_ready;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v_q     <= 1'b0;
          data_q  <= '0;
          carry_q <= 1'b0;
          inex_q  <= 1'b0;
          sign_q  <= 1'b0;
        end else if (ready1) begin
          v_q <= i_valid;
          if (i_valid) begin
            data_q  <= sum_d[OW-1:0];
            carry_q <= sum_d[OW];
            inex_q  <= inexact;
            sign_q  <= i_sign;
          end
        end
      end

      assign o_ready   = ready1;
      assign o_valid   = v_q;
      assign o_data    = data_q;
      assign o_carry   = carry_q;
      assign o_inexact = inex_q;
      assign o_sign    = sign_q;
    end else begin : g_pn
      logic          v1_q;
      logic [OW-1:0] kept1_q;
      logic          inc1_q;
      logic          inex1_q;
      logic          sign1_q;
      logic          v2_q;
      logic [OW-1:0] data2_q;
      logic          carry2_q;
      logic          inex2_q;
      logic          sign2_q;
      logic          ready1;
      logic          ready2;
      logic          ready3;
      logic [OW:0]   sum_d;

      assign ready1 = ~v1_q | ready2;
      assign ready2 = ~v2_q | ready3;
      assign sum_d  = {1'b0, kept1_q} + {{OW{1'b0}}, inc1_q};

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v1_q    <= 1'b0;
          kept1_q <= '0;
          inc1_q  <= 1'b0;
          inex1_q <= 1'b0;
          sign1_q <= 1'b0;
        end else if (ready1) begin
          v1_q <= i_valid;
          if (i_valid) begin
            kept1_q <= kept;
            inc1_q  <= inc;
            inex1_q <= inexact;
            sign1_q <= i_sign;
          end
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          v2_q     <= 1'b0;
          data2_q  <= '0;
          carry2_q <= 1'b0;
          inex2_q  <= 1'b0;
          sign2_q  <= 1'b0;
        end else if (ready2) begin
          v2_q <= v1_q;
          if (v1_q) begin
            data2_q  <= sum_d[OW-1:0];
            carry2_q <= sum_d[OW];
            inex2_q  <= inex1_q;
            sign2_q  <= sign1_q;
          end
        end
      end

      if (PIPE_STAGES == 3) begin : g_out
        logic          v3_q;
        logic [OW-1:0] data3_q;
        logic          carry3_q;
        logic          inex3_q;
        logic          sign3_q;

        assign ready3 = ~v3_q | i_ready;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            v3_q     <= 1'b0;
            data3_q  <= '0;
            carry3_q <= 1'b0;
            inex3_q  <= 1'b0;
            sign3_q  <= 1'b0;
          end else if (ready3) begin
            v3_q <= v2_q;
            if (v2_q) begin
              data3_q  <= data2_q;
              carry3_q <= carry2_q;
              inex3_q  <= inex2_q;
              sign3_q  <= sign2_q;
            end
          end
        end

        assign o_valid   = v3_q;
        assign o_data    = data3_q;
        assign o_carry   = carry3_q;
        assign o_inexact = inex3_q;
        assign o_sign    = sign3_q;
      end else begin : g_noout
        assign ready3    = i_ready;
        assign o_valid   = v2_q;
        assign o_data    = data2_q;
        assign o_carry   = carry2_q;
        assign o_inexact = inex2_q;
        assign o_sign    = sign2_q;
      end

      assign o_ready = ready1;
    end
  endgenerate

endmodule

// File: tb/tb_ipsxe_floating_point_round_pipe_v1_0.sv
// Scoreboard bench for the rounding pipe at IN_WIDTH=12, DROP=4, PIPE_STAGES=2.
module tb_ipsxe_floating_point_round_pipe_v1_0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [11:0] i_data = '0;
  logic        i_sign = 1'b0;
  logic [1:0]  i_rnd_mode = 2'b00;
  logic        o_valid;
  logic        i_ready;
  logic [7:0]  o_data;
  logic        o_carry;
  logic        o_inexact;
  logic        o_sign;

  ipsxe_floating_point_round_pipe_v1_0 #(
    .IN_WIDTH(12), .DROP(4), .PIPE_STAGES(2)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_data(i_data), .i_sign(i_sign), .i_rnd_mode(i_rnd_mode), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_carry(o_carry), .o_inexact(o_inexact),
    .o_sign(o_sign)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] d;
    logic        s;
    logic [1:0]  m;
    logic [7:0]  ed;
    logic        ec;
    logic        ex;
  } vec_t;

  int          testsRun = 0;
  int          testsFailed = 0;
  int          cyc = 0;
  int          pushed = 0;
  int          popped = 0;
  logic [10:0] expQ[$];
  vec_t        vecs[$];
  bit          bpMode = 1'b0;
  bit          readyHold = 1'b1;
  bit          bpReady = 1'b1;
  int          bpIdx = 0;
  bit          pattern[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  bit          prevStall = 1'b0;
  logic [11:0] prevOut = '0;

  assign i_ready = bpMode ? bpReady : readyHold;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(posedge i_clk) begin
    bpReady <= pattern[bpIdx];
    bpIdx   <= (bpIdx + 1) % 6;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference rounding by comparing the dropped remainder against one half.
  function automatic logic [10:0] refRound(input logic [11:0] d, input logic s, input logic [1:0] m);
    int          kept;
    int          rem;
    int          up;
    logic [8:0]  r9;
    kept = int'(d[11:4]);
    rem  = int'(d[3:0]);
    case (m)
      2'd0:    up = ((rem > 8) || (rem == 8 && (kept % 2) == 1)) ? 1 : 0;
      2'd1:    up = 0;
      2'd2:    up = (rem != 0 && !s) ? 1 : 0;
      default: up = (rem != 0 && s) ? 1 : 0;
    endcase
    r9 = 9'(kept + up);
    return {r9[8], r9[7:0], (rem != 0), s};
  endfunction

  task automatic applyStimulus(input logic [11:0] d, input logic s, input logic [1:0] m,
                               input logic [10:0] expw, output int accCyc);
    bit acc;
    acc = 1'b0;
    accCyc = 0;
    i_valid = 1'b1;
    i_data = d;
    i_sign = s;
    i_rnd_mode = m;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge i_clk);
      acc = o_ready;
      accCyc = cyc;
      @(posedge i_clk);
      #1;
    end
    i_valid = 1'b0;
    if (acc) begin
      expQ.push_back(expw);
      pushed++;
    end else begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && expQ.size() != 0; n++) @(posedge i_clk);
    #1;
    checkOutput("drain_timeout", expQ.size(), 0);
  endtask

  task automatic waitLatency(input int accCyc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge i_clk);
      seen = o_valid;
    end
    checkOutput("latency", seen ? (cyc - accCyc) : 32'hFFFF, 2);
  endtask

  // Output monitor: ready rule, stall stability and in-order scoreboard pops.
  always @(negedge i_clk) begin
    logic [11:0] cur;
    logic [10:0] e;
    cur = {o_valid, o_carry, o_data, o_inexact, o_sign};
    if (!i_rst_n) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("o_ready_rule", o_ready, !(expQ.size() == 2 && !i_ready));
      if (prevStall) checkOutput("stall_hold", cur, prevOut);
      if (o_valid && i_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat", cur[10:0], e);
          popped++;
        end
      end
      prevStall = o_valid && !i_ready;
      prevOut = cur;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    logic [11:0] rd;
    logic        rs;
    logic [1:0]  rm;

    vecs.push_back('{12'h128, 1'b0, 2'd0, 8'h12, 1'b0, 1'b1});
    vecs.push_back('{12'h138, 1'b0, 2'd0, 8'h14, 1'b0, 1'b1});
    vecs.push_back('{12'h129, 1'b0, 2'd0, 8'h13, 1'b0, 1'b1});
    vecs.push_back('{12'h118, 1'b0, 2'd0, 8'h12, 1'b0, 1'b1});
    vecs.push_back('{12'hFF8, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{12'hFF8, 1'b0, 2'd1, 8'hFF, 1'b0, 1'b1});
    vecs.push_back('{12'h121, 1'b0, 2'd2, 8'h13, 1'b0, 1'b1});
    vecs.push_back('{12'h121, 1'b1, 2'd2, 8'h12, 1'b0, 1'b1});
    vecs.push_back('{12'h121, 1'b1, 2'd3, 8'h13, 1'b0, 1'b1});
    vecs.push_back('{12'h121, 1'b0, 2'd3, 8'h12, 1'b0, 1'b1});
    vecs.push_back('{12'h121, 1'b1, 2'd1, 8'h12, 1'b0, 1'b1});
    vecs.push_back('{12'h120, 1'b0, 2'd0, 8'h12, 1'b0, 1'b0});
    vecs.push_back('{12'h120, 1'b1, 2'd1, 8'h12, 1'b0, 1'b0});
    vecs.push_back('{12'h120, 1'b1, 2'd2, 8'h12, 1'b0, 1'b0});
    vecs.push_back('{12'h120, 1'b0, 2'd3, 8'h12, 1'b0, 1'b0});
    vecs.push_back('{12'hFFF, 1'b1, 2'd3, 8'h00, 1'b1, 1'b1});

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("reset_valid", o_valid, 0);
    checkOutput("reset_ready", o_ready, 1);
    checkOutput("reset_payload", {o_carry, o_data, o_inexact, o_sign}, 0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    applyStimulus(vecs[0].d, vecs[0].s, vecs[0].m, {vecs[0].ec, vecs[0].ed, vecs[0].ex, vecs[0].s}, acc);
    waitLatency(acc);
    waitDrain();

    for (int i = 1; i < vecs.size(); i++)
      applyStimulus(vecs[i].d, vecs[i].s, vecs[i].m, {vecs[i].ec, vecs[i].ed, vecs[i].ex, vecs[i].s}, acc);
    waitDrain();

    bpMode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd = 12'($urandom);
      rs = 1'($urandom);
      rm = 2'($urandom_range(0, 3));
      applyStimulus(rd, rs, rm, refRound(rd, rs, rm), acc);
    end
    waitDrain();
    bpMode = 1'b0;

    readyHold = 1'b0;
    applyStimulus(12'h138, 1'b0, 2'd0, refRound(12'h138, 1'b0, 2'd0), acc);
    applyStimulus(12'hFF8, 1'b0, 2'd0, refRound(12'hFF8, 1'b0, 2'd0), acc);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", o_valid, 0);
    checkOutput("midreset_ready", o_ready, 1);
    expQ.delete();
    pushed = popped;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    readyHold = 1'b1;
    applyStimulus(12'h129, 1'b0, 2'd0, {1'b0, 8'h13, 1'b1, 1'b0}, acc);
    waitLatency(acc);
    waitDrain();
    repeat (4) @(posedge i_clk);
    #1;

    checkOutput("final_queue_empty", expQ.size(), 0);
    checkOutput("beat_count", popped, pushed);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ipsxe_floating_point_round_pipe_v1_0.md
Name: ipsxe_floating_point_round_pipe_v1_0

Overview:
Parametrised, pipelined mantissa rounding unit with a valid/ready handshake. It takes a wide fixed-point product such as a3*y, drops DROP low bits, and rounds the kept field in one of four IEEE modes. It reports the mantissa carry-out and the inexact flag. It replaces single-purpose fixed-RNE rounding slices inside the floating-point datapaths (invsqrt, reciprocal, mult).

Parameters:
IN_WIDTH, 60, width of the unrounded input field; must be greater than DROP+1.
DROP, 9, number of low bits discarded; must be at least 2 (guard bit plus at least one sticky bit).
PIPE_STAGES, 2, register stages from input to output; legal values are 1, 2 and 3.

Ports:
i_clk  in  1  clock; all registers on the rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_valid  in  1  input beat valid.
o_ready  out  1  unit can accept a beat this cycle.
i_data  in  IN_WIDTH  unrounded magnitude.
i_sign  in  1  sign of the value; used by the directed modes.
i_rnd_mode  in  2  00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf).
o_valid  out  1  output beat valid.
i_ready  in  1  downstream accepts the output beat.
o_data  out  IN_WIDTH-DROP  rounded kept field, modulo 2^(IN_WIDTH-DROP).
o_carry  out  1  rounding increment overflowed the kept field.
o_inexact  out  1  discarded bits were non-zero.
o_sign  out  1  i_sign carried along with the beat.

Behaviour:
- Field decode:
  - kept = i_data[IN_WIDTH-1:DROP]
  - lsb = i_data[DROP]
  - g = i_data[DROP-1]
  - s = OR of i_data[DROP-2:0]
- Increment by mode:
  - RNE: inc = g & (s | lsb)
  - RTZ: inc = 0
  - RUP: inc = ~sign & (g | s)
  - RDN: inc = sign & (g | s)
- Result: {o_carry, o_data} = kept + inc, computed at width IN_WIDTH-DROP+1. o_inexact = g | s, independent of mode.
- Stage partition:
  - PIPE_STAGES=1: decode and add complete before the single register.
  - PIPE_STAGES=2: stage 1 registers kept, inc, inexact and sign; stage 2 registers the sum.
  - PIPE_STAGES=3: adds an output register after stage 2.
- Each stage k holds a valid bit v_k and its payload.
- Stage k loads when its ready_k is high. ready_k = ~v_k | ready_(k+1). The last stage uses i_ready as ready_(k+1).
- o_ready = ready_1. A beat is accepted when i_valid & o_ready.
- o_valid = v_last. Output payload is taken from the last stage.
- Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Latency with no backpressure is exactly PIPE_STAGES cycles from acceptance to o_valid. Throughput is 1 beat per cycle.
- While o_valid=1 and i_ready=0, o_data, o_carry, o_inexact and o_sign hold stable.
- The ordering of beats is preserved. No beat is dropped or duplicated under any i_ready pattern.
- Payload registers load only when their stage loads. There are no X propagations from invalid beats into valid ones.
- Reset:
  - Every v_k is cleared, so o_valid=0 and o_ready=1 immediately on reset assertion, asynchronously.
  - o_data, o_carry, o_inexact and o_sign reset to 0.
  - Reset mid-operation discards all in-flight beats. The first beat accepted after deassertion emerges PIPE_STAGES cycles later.
- Simultaneous events: acceptance at stage 1 and drain from the last stage in the same cycle are both honoured, so a full pipeline with i_ready=1 keeps o_ready=1.
- Boundary: kept all-ones with inc=1 gives o_data=0 and o_carry=1. The unit does not renormalise; the consumer shifts.
- i_rnd_mode and i_sign are sampled per beat with i_data. A mode change between beats takes effect on the next accepted beat only.

Test Plan:
(All scenarios use IN_WIDTH=12, DROP=4, PIPE_STAGES=2.)
- RNE ties to even: i_data=0x128 gives o_data=0x12, inexact=1. i_data=0x138 gives 0x14, inexact=1. i_data=0x129 gives 0x13.
- Carry-out: RNE with i_data=0xFF8 gives o_data=0x00, o_carry=1, inexact=1. RTZ with the same input gives 0xFF, o_carry=0.
- Directed modes, i_data=0x121:
  - RUP sign=0 gives 0x13; RUP sign=1 gives 0x12.
  - RDN sign=1 gives 0x13; RDN sign=0 gives 0x12.
  - RTZ gives 0x12.
- Exact input: i_data=0x120 in all four modes gives 0x12 with inexact=0 and carry=0.
- Backpressure:
  - Stream 8 beats back-to-back while i_ready toggles 1,0,0,1,0,1...
  - Required: all 8 results in order, correct values, outputs stable during stalls.
  - o_ready drops only when both stages are full and i_ready=0.
  - With i_ready=1 throughout, first o_valid appears exactly 2 cycles after the first acceptance.
- Reset mid-flight: assert i_rst_n=0 with 2 beats in the pipe. Required: o_valid=0 and o_ready=1 immediately. After release, a new beat with 0x129 in RNE appears as 0x13 two cycles after acceptance, with no stale beat.
